// File: rtl/speaker_put_samples_if.sv
// Sample stream into the speaker DAC serialiser: valid/ready handshake plus data and strobe.
interface speaker_put_samples_if #(
  parameter int DATA_WIDTH = 16
);
  logic                    tvalid;
  logic [DATA_WIDTH-1:0]   tdata;
  logic [DATA_WIDTH/8-1:0] tstrb;
  logic                    tready;

  modport master (output tvalid, tdata, tstrb, input tready);
  modport slave  (input tvalid, tdata, tstrb, output tready);
endinterface

// File: rtl/speaker_put_samples.sv
// Buffers samples in a small FIFO and shifts one 16-bit DAC frame out per pacing tick.
// Define SPEAKER_HOLD_LAST_EN to re-send the last frame when a tick finds the FIFO empty.
module speaker_put_samples #(
  parameter int CLK_TRIG               = 2,
  parameter int SAMPLE_TRIG            = 128,
  parameter int RAM_ADDR_WIDTH         = 3,
  parameter int C_S00_AXIS_TDATA_WIDTH = 16
) (
  input  logic                 s00_axis_aclk,
  input  logic                 s00_axis_aresetn,
  speaker_put_samples_if.slave s00_axis,
  output logic                 spi_clock,
  output logic                 spi_chipselect,
  output logic                 spi_data,
  output logic                 underflow
);
  localparam int DEPTH = 1 << RAM_ADDR_WIDTH;
  localparam int W     = C_S00_AXIS_TDATA_WIDTH;
  localparam int AW    = RAM_ADDR_WIDTH;
  localparam int PW    = $clog2(SAMPLE_TRIG);
  localparam int HW    = $clog2(CLK_TRIG + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

  logic [11:0] mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        full, empty, push, pop;

  logic [PW-1:0] pace_cnt;
  logic          tick;

  state_t        state, state_n;
  logic [HW-1:0] half_cnt, half_n;
  logic [4:0]    edge_cnt, edge_n;
  logic [15:0]   shreg, shreg_n, frame_sel;
  logic          start;
  logic          sclk_n, cs_n, sdat_n;
`ifdef SPEAKER_HOLD_LAST_EN
  logic [15:0]   last_frame, last_n;
`endif

  assign empty           = (wr_ptr == rd_ptr);
  assign full            = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign s00_axis.tready = s00_axis_aresetn && !full;
  assign push            = s00_axis.tvalid && s00_axis.tready;

  always_ff @(posedge s00_axis_aclk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= s00_axis.tdata[W-1 -: 12];
    end
  end

  always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
    if (!s00_axis_aresetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  assign tick = (pace_cnt == PW'(SAMPLE_TRIG - 1));

  always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
    if (!s00_axis_aresetn) begin
      pace_cnt <= '0;
    end else if (tick) begin
      pace_cnt <= '0;
    end else begin
      pace_cnt <= pace_cnt + 1'b1;
    end
  end

  always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
    if (!s00_axis_aresetn) begin
      state          <= IDLE;
      half_cnt       <= '0;
      edge_cnt       <= '0;
      shreg          <= '0;
      spi_clock      <= 1'b1;
      spi_chipselect <= 1'b1;
      spi_data       <= 1'b0;
`ifdef SPEAKER_HOLD_LAST_EN
      last_frame     <= '0;
`endif
    end else begin
      state          <= state_n;
      half_cnt       <= half_n;
      edge_cnt       <= edge_n;
      shreg          <= shreg_n;
      spi_clock      <= sclk_n;
      spi_chipselect <= cs_n;
      spi_data       <= sdat_n;
`ifdef SPEAKER_HOLD_LAST_EN
      last_frame     <= last_n;
`endif
    end
  end

  always_comb begin
    state_n   = state;
    half_n    = half_cnt;
    edge_n    = edge_cnt;
    shreg_n   = shreg;
    sclk_n    = spi_clock;
    cs_n      = spi_chipselect;
    sdat_n    = spi_data;
    pop       = 1'b0;
    underflow = 1'b0;
    start     = 1'b0;
    frame_sel = {4'b0000, mem[rd_ptr[AW-1:0]]};
`ifdef SPEAKER_HOLD_LAST_EN
    last_n    = last_frame;
`endif

    case (state)
      IDLE: begin
        if (tick) begin
          if (!empty) begin
            pop   = 1'b1;
            start = 1'b1;
          end else begin
            underflow = 1'b1;
`ifdef SPEAKER_HOLD_LAST_EN
            start     = 1'b1;
            frame_sel = last_frame;
`endif
          end
        end
        if (start) begin
          state_n = SHIFT;
          half_n  = '0;
          edge_n  = '0;
          shreg_n = frame_sel;
          sclk_n  = 1'b1;
          cs_n    = 1'b0;
          sdat_n  = frame_sel[15];
`ifdef SPEAKER_HOLD_LAST_EN
          last_n  = frame_sel;
`endif
        end
      end

      SHIFT: begin
        // edge_cnt counts completed half-periods; the 32nd one ends the frame
        if (half_cnt == HW'(CLK_TRIG - 1)) begin
          half_n = '0;
          edge_n = edge_cnt + 5'd1;
          if (edge_cnt == 5'd31) begin
            state_n = GAP;
            sclk_n  = 1'b1;
            cs_n    = 1'b1;
            sdat_n  = 1'b0;
          end else begin
            sclk_n = !spi_clock;
            if (!spi_clock) begin
              shreg_n = {shreg[14:0], 1'b0};
              sdat_n  = shreg[14];
            end
          end
        end else begin
          half_n = half_cnt + 1'b1;
        end
      end

      GAP: begin
        if (half_cnt == HW'(CLK_TRIG - 1)) begin
          state_n = IDLE;
          half_n  = '0;
        end else begin
          half_n = half_cnt + 1'b1;
        end
      end

      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_speaker_put_samples.sv
// Directed bench for speaker_put_samples: scoreboard of expected DAC frames plus timing checks.
module tb_speaker_put_samples;
  localparam int CT = 2;
  localparam int ST = 128;
  localparam int AW = 3;
  localparam int DW = 16;
`ifdef SPEAKER_HOLD_LAST_EN
  localparam int HOLD = 1;
`else
  localparam int HOLD = 0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  speaker_put_samples_if #(.DATA_WIDTH(DW)) bus ();
  logic spi_clock, spi_chipselect, spi_data, underflow;

  speaker_put_samples #(
    .CLK_TRIG(CT), .SAMPLE_TRIG(ST), .RAM_ADDR_WIDTH(AW), .C_S00_AXIS_TDATA_WIDTH(DW)
  ) dut (
    .s00_axis_aclk(clk),
    .s00_axis_aresetn(rst_n),
    .s00_axis(bus),
    .spi_clock(spi_clock),
    .spi_chipselect(spi_chipselect),
    .spi_data(spi_data),
    .underflow(underflow)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [15:0] exp_q[$];
  int          start_q[$];
  logic [15:0] last_exp = '0;
  int          frames_done = 0;
  int          uf_cnt = 0;
  int          uf_cyc = -1;

  logic        in_frame = 1'b0;
  int          low_cnt = 0;
  int          falls = 0;
  logic [15:0] bits = '0;
  logic        prev_cs = 1'b1, prev_clk = 1'b1, prev_uf = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Frame capture on falling spi_clock, compared against the scoreboard at chipselect release
  always @(negedge clk) begin
    if (!rst_n) begin
      in_frame = 1'b0;
    end else begin
      if (underflow) begin
        uf_cnt++;
        uf_cyc = cyc;
        chk("uf_width", prev_uf, 0);
        if (HOLD != 0) exp_q.push_back(last_exp);
      end
      if (prev_cs && !spi_chipselect) begin
        in_frame = 1'b1;
        low_cnt  = 0;
        falls    = 0;
        bits     = '0;
        start_q.push_back(cyc);
      end
      if (!spi_chipselect) begin
        low_cnt++;
        if (prev_clk && !spi_clock) begin
          bits = {bits[14:0], spi_data};
          falls++;
        end
      end
      if (!prev_cs && spi_chipselect && in_frame) begin
        logic [15:0] e;
        in_frame = 1'b0;
        frames_done++;
        chk("cs_low_cycles", low_cnt, 64);
        chk("fall_edges", falls, 16);
        chk("frame_expected", (exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("frame_bits", bits, e);
          last_exp = e;
        end
      end
    end
    prev_cs  = spi_chipselect;
    prev_clk = spi_clock;
    prev_uf  = underflow;
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] d, output int acc_cyc);
    int n = 0;
    bus.tvalid = 1'b1;
    bus.tdata  = d;
    while (!bus.tready && n < 300) begin
      step();
      n++;
    end
    chk("push_accept", (n < 300), 1);
    acc_cyc = cyc;
    if (n < 300) exp_q.push_back({4'b0000, d[15:4]});
    step();
    bus.tvalid = 1'b0;
  endtask

  task automatic wait_frames(input int target, input int budget, input string tag);
    int n = 0;
    while (frames_done < target && n < budget) begin
      step();
      n++;
    end
    chk(tag, (frames_done >= target), 1);
  endtask

  task automatic wait_uf(input int budget, input string tag);
    int u0 = uf_cnt;
    int n  = 0;
    while (uf_cnt == u0 && n < budget) begin
      step();
      n++;
    end
    chk(tag, (uf_cnt > u0), 1);
  endtask

  initial begin
    int c_rel, cu, acc, fd, u0, s0, n;
    logic [15:0] words [9];
    bus.tvalid = 1'b0;
    bus.tdata  = '0;
    bus.tstrb  = '1;

    // Reset values
    step();
    step();
    chk("rst_cs", spi_chipselect, 1);
    chk("rst_sclk", spi_clock, 1);
    chk("rst_sdata", spi_data, 0);
    chk("rst_tready", bus.tready, 0);
    chk("rst_uf", underflow, 0);
    rst_n = 1'b1;
    c_rel = cyc;
    step();
    chk("tready_after_rel", bus.tready, 1);

    // Single frame 0xABCD -> 0x0ABC on the first tick
    push(16'hABCD, acc);
    wait_frames(1, 400, "frame1_wait");
    chk("frame1_start", start_q[0], c_rel + 128);
    chk("frame1_no_uf", uf_cnt, 0);

    // Empty FIFO tick
    wait_uf(200, "uf1_wait");
    chk("uf1_cycle", uf_cyc, c_rel + 255);
    chk("uf1_cs_high", spi_chipselect, 1);
    fd = frames_done;
    repeat (80) step();
    chk("uf1_frames", frames_done, fd + HOLD);

    // Nine back-to-back pushes right after a tick
    wait_uf(200, "sync_d");
    cu = cyc;
    fd = frames_done;
    u0 = uf_cnt;
    for (int i = 0; i < 9; i++) words[i] = 16'h1000 * i[15:0] + 16'h0123 * (i[15:0] + 16'd1);
    for (int i = 0; i < 8; i++) push(words[i], acc);
    chk("tready_full", bus.tready, 0);
    push(words[8], acc);
    chk("ninth_accept_cycle", acc, cu + 129);
    chk("d_no_uf", uf_cnt, u0);
    wait_frames(fd + 9 + HOLD, 1500, "d_frames_wait");

    // Four preloaded words: frames 128 cycles apart, then underflow on the fifth tick
    wait_uf(300, "sync_e");
    cu = cyc;
    fd = frames_done;
    s0 = start_q.size();
    push(16'hF00F, acc);
    push(16'h0FF0, acc);
    push(16'h8001, acc);
    push(16'h7FFE, acc);
    wait_frames(fd + 4 + HOLD, 700, "e_frames_wait");
    n = start_q.size();
    chk("e_first_start", start_q[s0 + HOLD], cu + 129);
    chk("e_gap1", start_q[n-3] - start_q[n-4], 128);
    chk("e_gap2", start_q[n-2] - start_q[n-3], 128);
    chk("e_gap3", start_q[n-1] - start_q[n-2], 128);
    wait_uf(200, "e_uf_wait");
    chk("e_uf_cycle", uf_cyc, start_q[n-1] + 127);

    // Reset in the middle of bit 6 of frame 0x06E4
    s0 = start_q.size();
    push(16'h6E4F, acc);
    n = 0;
    while (start_q.size() < s0 + 1 + HOLD && n < 400) begin
      step();
      n++;
    end
    chk("f_frame_started", (start_q.size() >= s0 + 1 + HOLD), 1);
    repeat (25) step();
    chk("f_cs_before_rst", spi_chipselect, 0);
    chk("f_bit6", spi_data, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("f_rst_cs", spi_chipselect, 1);
    chk("f_rst_sclk", spi_clock, 1);
    chk("f_rst_sdata", spi_data, 0);
    chk("f_rst_tready", bus.tready, 0);
    chk("f_rst_uf", underflow, 0);
    repeat (3) step();
    exp_q.delete();
    last_exp = '0;
    fd = frames_done;
    rst_n = 1'b1;
    c_rel = cyc;
    step();
    chk("f_tready_after_rel", bus.tready, 1);
    wait_uf(200, "f_uf_wait");
    chk("f_uf_cycle", uf_cyc, c_rel + 127);
    repeat (80) step();
    chk("f_frames_after_rst", frames_done, fd + HOLD);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end
endmodule

// File: doc/speaker_put_samples.md
SPEAKER_PUT_SAMPLES -- requirements
Module: speaker_put_samples

Interface
REQ-001 CLK_TRIG, 2, aclk cycles per spi_clock half-period (>=1).
REQ-002 SAMPLE_TRIG, 128, aclk cycles between frame-start opportunities (>= 33*CLK_TRIG+2).
REQ-003 RAM_ADDR_WIDTH, 3, FIFO depth = 2**RAM_ADDR_WIDTH words.
REQ-004 C_S00_AXIS_TDATA_WIDTH, 16, sample width (>=12).
REQ-005 s00_axis_aclk  in  1  sole clock; all logic on rising edge.
REQ-006 s00_axis_aresetn  in  1  asynchronous, active-low reset.
REQ-007 s00_axis_tvalid  in  1  sample valid.
REQ-008 s00_axis_tdata  in  C_S00_AXIS_TDATA_WIDTH  signed/unsigned sample; top 12 bits used.
REQ-009 s00_axis_tstrb  in  C_S00_AXIS_TDATA_WIDTH/8  ignored.
REQ-010 s00_axis_tready  out  1  FIFO not full.
REQ-011 spi_clock  out  1  DAC serial clock, idles high.
REQ-012 spi_chipselect  out  1  DAC sync, active-low.
REQ-013 spi_data  out  1  DAC serial data, MSB first.
REQ-014 underflow  out  1  one-cycle pulse: pacing tick found FIFO empty.

Function
REQ-015 FIFO: push on tvalid&&tready; tready = !full; pop only at frame start; pushed word visible to pop the cycle after push.
REQ-016 Pacing counter SHALL count 0..SAMPLE_TRIG-1 continuously; tick when count==SAMPLE_TRIG-1.
REQ-017 States IDLE, SHIFT, GAP; tick honoured only in IDLE, ignored in SHIFT/GAP.
REQ-018 IDLE+tick+FIFO non-empty: pop word, load frame = {4'b0000, tdata[W-1:W-12]}, enter SHIFT next cycle.
REQ-019 IDLE+tick+FIFO empty: underflow=1 for that cycle; behaviour per REQ-029/030.
REQ-020 SHIFT first cycle: spi_chipselect=0, spi_clock=1, spi_data=frame[15].
REQ-021 spi_clock SHALL toggle every CLK_TRIG cycles in SHIFT; DAC samples on falling edge; spi_data advances one bit at each rising edge.
REQ-022 After 16th falling edge, at next rising point (32*CLK_TRIG cycles after SHIFT entry): spi_chipselect=1, spi_clock=1, spi_data=0, enter GAP.
REQ-023 GAP SHALL hold chipselect high CLK_TRIG cycles, then IDLE.
REQ-024 spi_chipselect low exactly 32*CLK_TRIG cycles per frame; exactly 16 falling spi_clock edges per frame.
REQ-025 Frames from a non-empty FIFO SHALL start exactly SAMPLE_TRIG cycles apart.
REQ-026 Full FIFO with pop same cycle: tready stays 0 that cycle; rises next cycle.

Reset
REQ-027 aresetn low SHALL immediately force: spi_chipselect=1, spi_clock=1, spi_data=0, tready=0, underflow=0, state IDLE, FIFO empty, pacing counter 0, last-sample register 0.
REQ-028 Reset mid-frame SHALL abort the frame; no partial frame resumes; tready=1 on first cycle after release.

Configuration
REQ-029 With SPEAKER_HOLD_LAST_EN defined: on underflow tick the last transmitted frame (0 after reset) SHALL be re-sent per REQ-020..024.
REQ-030 Without SPEAKER_HOLD_LAST_EN: on underflow tick no frame; chipselect stays high; state stays IDLE.

Verification (CLK_TRIG=2, SAMPLE_TRIG=128, RAM_ADDR_WIDTH=3)
REQ-031 Push 0xABCD, wait tick -> chipselect low 64 cycles; bits 0000_1010_1011_1100 captured on 16 falling edges; underflow=0.
REQ-032 Push 9 words back-to-back -> tready falls after 8th accepted; 9th held; tready rises the cycle after first frame pop.
REQ-033 Empty FIFO, tick -> underflow pulse 1 cycle; without macro chipselect stays 1; with macro previous frame (e.g. 0x0ABC) re-sent.
REQ-034 Assert aresetn low at 7th bit of a frame -> same cycle chipselect=1, spi_clock=1, spi_data=0, tready=0; after release no frame until new push and tick.
REQ-035 Preload 4 words -> 4 frames start exactly 128 cycles apart, then underflow pulse on 5th tick.
